// File: rtl/nand2_exerciser.sv
// Stimulus/checker for a two-input NAND cell: walks {a,b} through 00..11 for
// ROUNDS passes, samples c after SETTLE cycles per vector and tallies mismatches.
module nand2_exerciser #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned ROUNDS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       c_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [3:0] fail_vec
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned RND_W  = 16;
    localparam int unsigned ERR_W  = 8;
    localparam int unsigned VEC_W  = 2;
    localparam int unsigned FAIL_W = 4;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [RND_W-1:0] ROUND_LAST  = RND_W'(ROUNDS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [VEC_W-1:0]    vec, vec_n;
    logic [CNT_W-1:0]    settle_cnt, settle_cnt_n;
    logic [RND_W-1:0]    round_cnt, round_cnt_n;
    logic                a_n, b_n, busy_n, done_n, pass_n;
    logic [ERR_W-1:0]    err_n;
    logic [FAIL_W-1:0]   fail_n;
    logic                mismatch_c;

    assign mismatch_c = (c_in != ~(vec[1] & vec[0]));

    // State and all output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            round_cnt  <= '0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
        end else begin
            state      <= state_n;
            vec        <= vec_n;
            settle_cnt <= settle_cnt_n;
            round_cnt  <= round_cnt_n;
            a_out      <= a_n;
            b_out      <= b_n;
            busy       <= busy_n;
            done       <= done_n;
            pass       <= pass_n;
            err_count  <= err_n;
            fail_vec   <= fail_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n      = state;
        vec_n        = vec;
        settle_cnt_n = settle_cnt;
        round_cnt_n  = round_cnt;
        a_n          = a_out;
        b_n          = b_out;
        busy_n       = busy;
        done_n       = done;
        pass_n       = pass;
        err_n        = err_count;
        fail_n       = fail_vec;

        case (state)
            IDLE: begin
                a_n = 1'b0;
                b_n = 1'b0;
                if (start) begin
                    state_n      = DRIVE;
                    vec_n        = '0;
                    settle_cnt_n = '0;
                    round_cnt_n  = '0;
                    busy_n       = 1'b1;
                    done_n       = 1'b0;
                    pass_n       = 1'b0;
                    err_n        = '0;
                    fail_n       = '0;
                end
            end

            DRIVE: begin
                settle_cnt_n = settle_cnt + CNT_W'(1);
                if (settle_cnt == SETTLE_LAST) begin
                    state_n = SAMPLE;
                end
            end

            SAMPLE: begin
                if (mismatch_c) begin
                    err_n  = (err_count == ERR_MAX) ? err_count : err_count + ERR_W'(1);
                    fail_n = fail_vec | FAIL_W'(FAIL_W'(1) << vec);
                end
                // Final pass must reflect the comparison made on this edge
                if (vec == VEC_W'(3) && round_cnt == ROUND_LAST) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (err_n == '0);
                    a_n     = 1'b0;
                    b_n     = 1'b0;
                end else begin
                    state_n      = DRIVE;
                    vec_n        = vec + VEC_W'(1);
                    settle_cnt_n = '0;
                    if (vec == VEC_W'(3)) begin
                        round_cnt_n = round_cnt + RND_W'(1);
                    end
                    a_n = vec_n[1];
                    b_n = vec_n[0];
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
